// File: rtl/add_pkg.sv
// Shared constants and helpers for the pipelined integer adder/subtractor.
package add_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One ripple slice per pipeline stage.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB.
module chunk_adder
  import add_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    one_bit_full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/one_bit_full_adder.sv
// Single-bit full adder cell used to build the ripple slices.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit add/sub: one CHUNK-bit ripple slice per stage, carries and
// unconsumed operand chunks registered between stages, global stall on backpressure.
module pipelined_add_sub
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             op_sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);
  localparam int unsigned LAST   = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

  // Per-stage registers; operand skew registers keep the next chunk at bit 0.
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [WIDTH-1:0]  res_q   [STAGES];
  logic              carry_q [STAGES];
  logic              overflow_q;
  logic              zero_q;

  // Stage inputs: stage 0 from the ports, stage k from stage k-1 registers.
  logic              stage_v   [STAGES];
  logic [WIDTH-1:0]  stage_a   [STAGES];
  logic [WIDTH-1:0]  stage_b   [STAGES];
  logic [WIDTH-1:0]  stage_res [STAGES];
  logic              stage_cin [STAGES];
  logic [WIDTH-1:0]  next_res  [STAGES];

  logic [CHUNK-1:0]  chunk_sum  [STAGES];
  logic              chunk_cout [STAGES];
  logic              chunk_cmsb [STAGES];

  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  assign eff_b   = (op_sub == OP_SUB) ? ~y : y;
  assign eff_cin = (op_sub == OP_ADD) ? carry_in : 1'b1;

  always_comb begin
    stage_v[0]   = in_valid;
    stage_a[0]   = x;
    stage_b[0]   = eff_b;
    stage_res[0] = '0;
    stage_cin[0] = eff_cin;
    for (int k = 1; k < STAGES; k++) begin
      stage_v[k]   = valid_q[k-1];
      stage_a[k]   = a_q[k-1];
      stage_b[k]   = b_q[k-1];
      stage_res[k] = res_q[k-1];
      stage_cin[k] = carry_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (stage_a[g][CHUNK-1:0]),
      .b    (stage_b[g][CHUNK-1:0]),
      .cin  (stage_cin[g]),
      .sum  (chunk_sum[g]),
      .cout (chunk_cout[g]),
      .c_msb(chunk_cmsb[g])
    );
  end

  // Merge this stage's result chunk above the already-resolved lower chunks.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      next_res[k] = stage_res[k] | (WIDTH'(chunk_sum[k]) << (k * CHUNK));
    end
  end

  // Data only loads behind a valid token so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        res_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= stage_v[k];
        if (stage_v[k]) begin
          a_q[k]     <= stage_a[k] >> CHUNK;
          b_q[k]     <= stage_b[k] >> CHUNK;
          res_q[k]   <= next_res[k];
          carry_q[k] <= chunk_cout[k];
        end
      end
      if (stage_v[LAST]) begin
        overflow_q <= chunk_cmsb[LAST] ^ chunk_cout[LAST];
        zero_q     <= (next_res[LAST] == '0);
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign sum       = res_q[LAST];
  assign carry_out = carry_q[LAST];
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
